// File: rtl/dmr_pkg.sv
// Shared constants for the data-memory responder: MMIO register map,
// STATUS bit layout and address-region decode values.
package dmr_pkg;

  localparam logic [3:0] OFF_OUT_DATA = 4'h0;
  localparam logic [3:0] OFF_STATUS   = 4'h4;
  localparam logic [3:0] OFF_CYCLE    = 4'h8;
  localparam logic [3:0] OFF_DONE     = 4'hC;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;

  function automatic logic [31:0] status_word(input logic [7:0] cnt,
                                              input logic ovf,
                                              input logic full,
                                              input logic empty);
    logic [31:0] s;
    s = '0;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    s[ST_OVF]   = ovf;
    s[ST_COUNT_LSB +: 8] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO only lands when a pop
// frees the slot on the same edge. Head is shown combinationally, 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: async-read word RAM plus
// an MMIO window with a byte output FIFO, STATUS, CYCLE and DONE registers.
module data_mem_responder
  import dmr_pkg::*;
#(
  parameter int          AW         = 10,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done,
  output logic        bus_err
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * (2 ** AW));

  logic [31:0] ram [2 ** AW];
  logic [31:0] off;
  logic [3:0]  moff;
  region_e     region;

  logic          wr_mmio, push, pop, drop;
  logic          f_empty, f_full;
  logic [CW-1:0] f_count;
  logic          ovf;
  logic [31:0]   cycle;

  always_comb begin
    off    = Addr - MMIO_BASE;
    moff   = {off[3:2], 2'b00};
    region = REG_NONE;
    if (Addr < RAM_BYTES)                         region = REG_RAM;
    else if (Addr >= MMIO_BASE && off < 32'd16)   region = REG_MMIO;
  end

  assign wr_mmio   = MemWrite && (region == REG_MMIO);
  assign push      = wr_mmio && (moff == OFF_OUT_DATA);
  assign out_valid = !f_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = push && f_full && !pop;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (WriteData[7:0]),
    .pop   (pop),
    .dout  (out_data),
    .empty (f_empty),
    .full  (f_full),
    .count (f_count)
  );

  // RAM has no reset and keeps accepting writes even on the reset edge.
  always_ff @(posedge clk) begin
    if (MemWrite && region == REG_RAM) ram[Addr[AW+1:2]] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf     <= 1'b0;
      done    <= 1'b0;
      bus_err <= 1'b0;
      cycle   <= '0;
    end else begin
      if (wr_mmio && moff == OFF_CYCLE) cycle <= '0;
      else                              cycle <= cycle + 32'd1;
      if (drop) ovf <= 1'b1;
      else if (wr_mmio && moff == OFF_STATUS && WriteData[ST_OVF]) ovf <= 1'b0;
      if (wr_mmio && moff == OFF_DONE) done <= 1'b1;
      // No read strobe exists, so any idle cycle off the map counts as a read.
      if (region == REG_NONE) bus_err <= 1'b1;
    end
  end

  always_comb begin
    ReadData = '0;
    case (region)
      REG_RAM: ReadData = ram[Addr[AW+1:2]];
      REG_MMIO: begin
        case (moff)
          OFF_STATUS: ReadData = status_word(8'(f_count), ovf, f_full, f_empty);
          OFF_CYCLE:  ReadData = cycle;
          OFF_DONE:   ReadData = {31'b0, done};
          default:    ReadData = '0;
        endcase
      end
      default: ReadData = '0;
    endcase
  end

endmodule
